// File: rtl/rat_branch_pkg.sv
// Shared RAT branch definitions: branch-type codes, 2-bit counter encodings, helpers.
package rat_branch_pkg;

  localparam int unsigned TYPE_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned STAT_W = 16;

  localparam logic [TYPE_W-1:0] BR_NONE  = 4'd0;
  localparam logic [TYPE_W-1:0] BR_BRCC  = 4'd1;
  localparam logic [TYPE_W-1:0] BR_BRCS  = 4'd2;
  localparam logic [TYPE_W-1:0] BR_BREQ  = 4'd3;
  localparam logic [TYPE_W-1:0] BR_BRN   = 4'd4;
  localparam logic [TYPE_W-1:0] BR_BRNE  = 4'd5;
  localparam logic [TYPE_W-1:0] BR_CALL  = 4'd6;
  localparam logic [TYPE_W-1:0] BR_RET   = 4'd7;
  localparam logic [TYPE_W-1:0] BR_RETID = 4'd8;
  localparam logic [TYPE_W-1:0] BR_RETIE = 4'd9;

  localparam logic [CNT_W-1:0] CNT_SNT   = 2'b00;
  localparam logic [CNT_W-1:0] CNT_WNT   = 2'b01;
  localparam logic [CNT_W-1:0] CNT_WT    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ST    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_RESET = CNT_WNT;

  function automatic logic is_conditional(input logic [TYPE_W-1:0] t);
    return (t == BR_BRCC) || (t == BR_BRCS) || (t == BR_BREQ) || (t == BR_BRNE);
  endfunction

  function automatic logic is_unconditional(input logic [TYPE_W-1:0] t);
    return (t == BR_BRN) || (t == BR_CALL) || (t == BR_RET) ||
           (t == BR_RETID) || (t == BR_RETIE);
  endfunction

  function automatic logic is_branch(input logic [TYPE_W-1:0] t);
    return is_conditional(t) || is_unconditional(t);
  endfunction

  // Saturating step of a 2-bit direction counter.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic taken);
    logic [CNT_W-1:0] n;
    n = c;
    if (taken && (c != CNT_ST)) n = c + CNT_W'(1);
    else if (!taken && (c != CNT_SNT)) n = c - CNT_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// 16-bit saturating event counter with synchronous clear; only built when
// BRANCH_PREDICTOR_STATS_EN is defined.
`ifdef BRANCH_PREDICTOR_STATS_EN
module bp_stat_counter
  import rat_branch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [STAT_W-1:0] o_count
);

  logic [STAT_W-1:0] r_count;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {STAT_W{1'b1}})) begin
      r_count <= r_count + STAT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/branch_predictor.sv
// PC-indexed 2-bit saturating-counter direction predictor for the RAT fetch stage.
// Optional resolve statistics enabled by BRANCH_PREDICTOR_STATS_EN.
module branch_predictor
  import rat_branch_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INDEX_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [PC_W-1:0]   FETCH_PC,
  input  logic [TYPE_W-1:0] FETCH_TYPE,
  output logic              PREDICT_TAKEN,
  input  logic              UPD_VALID,
  input  logic [PC_W-1:0]   UPD_PC,
  input  logic [TYPE_W-1:0] UPD_TYPE,
  input  logic              UPD_TAKEN,
  input  logic              UPD_MISS,
  input  logic              CLR_STATS,
  output logic [STAT_W-1:0] BR_COUNT,
  output logic [STAT_W-1:0] MISS_COUNT
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [CNT_W-1:0]   r_table [DEPTH];
  logic [INDEX_W-1:0] w_fetch_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic               w_train;
  logic [CNT_W-1:0]   w_upd_cnt;
  logic [CNT_W-1:0]   w_fetch_cnt;

  assign w_fetch_idx = FETCH_PC[INDEX_W-1:0];
  assign w_upd_idx   = UPD_PC[INDEX_W-1:0];
  assign w_train     = UPD_VALID && is_conditional(UPD_TYPE);
  assign w_upd_cnt   = cnt_next(r_table[w_upd_idx], UPD_TAKEN);

  // Lookup sees a same-cycle training result at the same index.
  always_comb begin
    w_fetch_cnt   = r_table[w_fetch_idx];
    PREDICT_TAKEN = 1'b0;
    if (w_train && (w_upd_idx == w_fetch_idx)) w_fetch_cnt = w_upd_cnt;
    if (is_conditional(FETCH_TYPE)) begin
      PREDICT_TAKEN = w_fetch_cnt[1];
    end else if (is_unconditional(FETCH_TYPE)) begin
      PREDICT_TAKEN = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_table[INDEX_W'(i)] <= CNT_RESET;
    end else if (w_train) begin
      r_table[w_upd_idx] <= w_upd_cnt;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic w_count_en;
  logic w_unused;

  assign w_count_en = UPD_VALID && is_branch(UPD_TYPE);
  assign w_unused   = ^{FETCH_PC, UPD_PC};

  bp_stat_counter u_br_count (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_inc   (w_count_en),
    .i_clr   (CLR_STATS),
    .o_count (BR_COUNT)
  );

  bp_stat_counter u_miss_count (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_inc   (w_count_en && UPD_MISS),
    .i_clr   (CLR_STATS),
    .o_count (MISS_COUNT)
  );
`else
  logic w_unused;

  assign w_unused   = ^{FETCH_PC, UPD_PC, CLR_STATS, UPD_MISS};
  assign BR_COUNT   = '0;
  assign MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan items plus random traffic
// against an array-based reference model; honours BRANCH_PREDICTOR_STATS_EN.
module tb_branch_predictor;

  localparam int PC_W    = 10;
  localparam int INDEX_W = 5;
  localparam int DEPTH   = 32;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [PC_W-1:0]   FETCH_PC = '0;
  logic [3:0]        FETCH_TYPE = '0;
  logic              PREDICT_TAKEN;
  logic              UPD_VALID = 1'b0;
  logic [PC_W-1:0]   UPD_PC = '0;
  logic [3:0]        UPD_TYPE = '0;
  logic              UPD_TAKEN = 1'b0;
  logic              UPD_MISS = 1'b0;
  logic              CLR_STATS = 1'b0;
  logic [15:0]       BR_COUNT;
  logic [15:0]       MISS_COUNT;

  always #5 CLK = ~CLK;

  branch_predictor #(.PC_W(PC_W), .INDEX_W(INDEX_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .FETCH_PC      (FETCH_PC),
    .FETCH_TYPE    (FETCH_TYPE),
    .PREDICT_TAKEN (PREDICT_TAKEN),
    .UPD_VALID     (UPD_VALID),
    .UPD_PC        (UPD_PC),
    .UPD_TYPE      (UPD_TYPE),
    .UPD_TAKEN     (UPD_TAKEN),
    .UPD_MISS      (UPD_MISS),
    .CLR_STATS     (CLR_STATS),
    .BR_COUNT      (BR_COUNT),
    .MISS_COUNT    (MISS_COUNT)
  );

  typedef struct {
    logic        pred;
    logic [15:0] br;
    logic [15:0] miss;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain integer strengths 0..3, taken when >= 2.
  int m_tab[DEPTH];
  int m_br;
  int m_miss;

  function automatic bit is_cond(input int t);
    return (t == 1) || (t == 2) || (t == 3) || (t == 5);
  endfunction

  function automatic bit is_uncond(input int t);
    return (t == 4) || ((t >= 6) && (t <= 9));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 1;
    m_br   = 0;
    m_miss = 0;
  endtask

  // One cycle of stimulus; optionally pulls reset low mid-cycle.
  task automatic step(input int fpc, input int ftype, input int uv, input int upc,
                      input int utype, input int ut, input int um, input int clr,
                      input int rst_mid, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    if (rst_mid == 0) RST_N = 1'b1;
    FETCH_PC   = PC_W'(fpc);
    FETCH_TYPE = 4'(ftype);
    UPD_VALID  = 1'(uv);
    UPD_PC     = PC_W'(upc);
    UPD_TYPE   = 4'(utype);
    UPD_TAKEN  = 1'(ut);
    UPD_MISS   = 1'(um);
    CLR_STATS  = 1'(clr);
    e.br   = 16'(m_br);
    e.miss = 16'(m_miss);
    e.tag  = tag;
    if (rst_mid != 0) begin
      #1;
      RST_N = 1'b0;
      model_reset();
      e.br   = '0;
      e.miss = '0;
    end else begin
      if ((uv != 0) && is_cond(utype)) begin
        if (ut != 0) m_tab[upc % DEPTH] = (m_tab[upc % DEPTH] < 3) ? m_tab[upc % DEPTH] + 1 : 3;
        else         m_tab[upc % DEPTH] = (m_tab[upc % DEPTH] > 0) ? m_tab[upc % DEPTH] - 1 : 0;
      end
`ifdef BRANCH_PREDICTOR_STATS_EN
      if (clr != 0) begin
        m_br   = 0;
        m_miss = 0;
      end else if ((uv != 0) && (utype >= 1) && (utype <= 9)) begin
        if (m_br < 65535) m_br++;
        if ((um != 0) && (m_miss < 65535)) m_miss++;
      end
`endif
    end
    if (is_cond(ftype)) e.pred = (m_tab[fpc % DEPTH] >= 2);
    else                e.pred = is_uncond(ftype);
    q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      if (PREDICT_TAKEN !== mon_e.pred) begin
        n_fail++;
        $display("FAIL %s predict: got %0b expected %0b", mon_e.tag, PREDICT_TAKEN, mon_e.pred);
      end
      n_tests++;
      if (BR_COUNT !== mon_e.br) begin
        n_fail++;
        $display("FAIL %s br_count: got %0h expected %0h", mon_e.tag, BR_COUNT, mon_e.br);
      end
      n_tests++;
      if (MISS_COUNT !== mon_e.miss) begin
        n_fail++;
        $display("FAIL %s miss_count: got %0h expected %0h", mon_e.tag, MISS_COUNT, mon_e.miss);
      end
    end
  end

  initial begin
    int fpc, upc;
    model_reset();
    // Reset state and type decode.
    step(12'h000 % 1024, 1, 1, 'h3FF, 1, 1, 0, 0, 1, "rst_cond");
    step('h000, 6, 0, 0, 0, 0, 0, 0, 0, "uncond");
    step('h000, 0, 0, 0, 0, 0, 0, 0, 0, "none_type");
    step('h000, 12, 0, 0, 0, 0, 0, 0, 0, "type_c");
    // Single taken training, then alias lookup.
    step('h045, 3, 1, 'h045, 3, 1, 0, 0, 0, "train_045");
    step('h045, 3, 0, 0, 0, 0, 0, 0, 0, "look_045");
    step('h025, 3, 0, 0, 0, 0, 0, 0, 0, "alias_025");
    // Saturation at strong-taken and one step back.
    for (int i = 0; i < 4; i++) step('h011, 1, 1, 'h011, 1, 1, 0, 0, 0, "sat_up");
    step('h011, 1, 1, 'h011, 1, 0, 0, 0, 0, "sat_down");
    step('h011, 1, 0, 0, 0, 0, 0, 0, 0, "after_down");
    // Same-cycle forwarding on a fresh entry.
    step('h0A7, 5, 1, 'h0A7, 5, 1, 0, 0, 0, "fwd");
    // Unconditional / none / A-F updates leave the table alone.
    step('h0A8, 2, 1, 'h0A8, 4, 1, 0, 0, 0, "uncond_upd");
    step('h0A8, 2, 1, 'h0A8, 10, 1, 1, 0, 0, "type_a_upd");
    step('h0A8, 2, 0, 0, 0, 0, 0, 0, 0, "after_ignored");
    // Statistics from a clean reset.
    step('h000, 1, 1, 'h3FF, 1, 1, 0, 0, 1, "stat_rst");
    step('h000, 0, 1, 'h100, 4, 1, 0, 0, 0, "stat_b4");
    step('h000, 0, 1, 'h101, 5, 0, 1, 0, 0, "stat_b5m");
    step('h000, 0, 1, 'h102, 0, 1, 1, 0, 0, "stat_b0");
    step('h000, 0, 0, 0, 0, 0, 0, 0, 0, "stat_read");
    step('h000, 0, 1, 'h103, 1, 1, 1, 1, 0, "clr_upd");
    step('h000, 0, 0, 0, 0, 0, 0, 0, 0, "clr_read");
    // Random traffic with frequent index collisions.
    for (int i = 0; i < 3000; i++) begin
      upc = int'($urandom_range(0, 1023));
      fpc = ($urandom_range(0, 3) == 0) ? upc : int'($urandom_range(0, 1023));
      step(fpc, int'($urandom_range(0, 15)), int'($urandom_range(0, 3) != 0), upc,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 31) == 0), 0, "rand");
    end
`ifdef BRANCH_PREDICTOR_STATS_EN
    // Drive BR_COUNT to its ceiling and past it.
    step('h000, 0, 1, 'h3FF, 1, 1, 0, 0, 1, "sat_rst");
    for (int i = 0; i < 65535; i++) step('h000, 0, 1, 'h200, 4, 1, 0, 0, 0, "fill");
    step('h000, 0, 1, 'h200, 4, 1, 1, 0, 0, "over");
    step('h000, 0, 0, 0, 0, 0, 0, 0, 0, "sat_read");
`endif
    // Train, then asynchronous reset mid-update restores weak-NT.
    step('h011, 1, 1, 'h011, 1, 1, 1, 0, 0, "pre_rst1");
    step('h011, 1, 1, 'h011, 1, 1, 1, 0, 0, "pre_rst2");
    step('h011, 1, 1, 'h02A, 1, 1, 1, 0, 1, "mid_rst");
    step('h011, 1, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    repeat (3) @(posedge CLK);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
